fixed_128_accum: RTL and testbench

Streaming saturating accumulator sitting directly downstream of the 128-bit fixed-point adder stage in the gradient/validation path. It consumes a burst of exactly N signed Q120.8 operands over a valid/ready handshake. It folds each operand into a running 128-bit sum using the adder's sign-based overflow/underflow rule, then presents the final sum with sticky overflow/underflow flags on a valid/ready output port.

---
 rtl/fixed_128_accum_if.sv | 23 ++
 rtl/fixed_128_accum.sv | 102 ++++++++++
 tb/tb_fixed_128_accum.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_128_accum_if.sv
// rtl/fixed_128_accum_if.sv - operand/result stream bundle for the 128-bit saturating accumulator
interface fixed_128_accum_if;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_sum;
    logic         overflow;
    logic         underflow_q;
    logic         busy;

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, overflow, underflow_q, busy
    );

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, overflow, underflow_q, busy
    );
endinterface

// File: rtl/fixed_128_accum.sv
// rtl/fixed_128_accum.sv - burst accumulator of signed Q120.8 operands, saturation under FIXED_ACC_SATURATE_EN
module fixed_128_accum #(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fixed_128_accum_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t       state_q, state_d;
    logic [127:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic         ovf_q, unf_q;

    logic [127:0] raw;
    logic         ovf, unf;
    logic         beat;
    logic         in_ready_c;

    // Accepted operand: in_ready is a pure state decode, so this is the only in_valid gating.
    assign beat = bus.in_valid & in_ready_c;

    // Wrap-around sum plus sign-based overflow/underflow detection, and the next acc value.
    always_comb begin
        raw = acc_q + bus.in_data;
        ovf = ~acc_q[127] & ~bus.in_data[127] &  raw[127];
        unf =  acc_q[127] &  bus.in_data[127] & ~raw[127];
`ifdef FIXED_ACC_SATURATE_EN
        if (ovf) begin
            acc_d = {1'b0, {127{1'b1}}};
        end else if (unf) begin
            acc_d = {1'b1, {127{1'b0}}};
        end else begin
            acc_d = raw;
        end
`else
        acc_d = raw;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start only matters in IDLE, in_valid only in ACC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = ACC;
            ACC:  if (beat && (cnt_q == LAST_CNT)) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on state alone.
    always_comb begin
        in_ready_c    = (state_q == ACC);
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
    end

    // Accumulator, beat counter and sticky flags; cleared on burst start, frozen outside ACC beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if ((state_q == IDLE) && bus.start) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            ovf_q <= ovf_q | ovf;
            unf_q <= unf_q | unf;
        end
    end

    assign bus.out_sum     = acc_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow_q = unf_q;

endmodule

// File: tb/tb_fixed_128_accum.sv
// tb/tb_fixed_128_accum.sv - scoreboard bench for fixed_128_accum with randomized bursts
module tb_fixed_128_accum;

    localparam int N = 4;

    typedef struct {
        logic [127:0] sum;
        logic         ovf;
        logic         unf;
    } exp_t;

    logic clk;
    logic rst_n;
    fixed_128_accum_if bus ();

    fixed_128_accum #(.N_SAMPLES(N), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    logic [127:0] ops [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact integer sum, clamped (or wrapped) whenever it leaves the 128-bit signed range.
    function automatic exp_t model();
        exp_t e;
        logic signed [129:0] s;
        logic signed [129:0] maxv;
        logic signed [129:0] minv;
        maxv = {3'b000, {127{1'b1}}};
        minv = {3'b111, {127{1'b0}}};
        s = '0;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        for (int i = 0; i < N; i++) begin
            s = s + $signed({{2{ops[i][127]}}, ops[i]});
            if (s > maxv) begin
                e.ovf = 1'b1;
`ifdef FIXED_ACC_SATURATE_EN
                s = maxv;
`endif
            end else if (s < minv) begin
                e.unf = 1'b1;
`ifdef FIXED_ACC_SATURATE_EN
                s = minv;
`endif
            end
            s = $signed({{2{s[127]}}, s[127:0]});
        end
        e.sum = s[127:0];
        return e;
    endfunction

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", bus.out_sum);
            end else begin
                e = sb_q.pop_front();
                check("out_sum", bus.out_sum, e.sum);
                check("overflow", {127'b0, bus.overflow}, {127'b0, e.ovf});
                check("underflow_q", {127'b0, bus.underflow_q}, {127'b0, e.unf});
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One complete burst of ops[]; gaps randomizes in_valid, pulse_start toggles start while busy.
    task automatic run_burst(input bit gaps, input int out_delay, input bit pulse_start);
        int i;
        int guard;
        logic [127:0] held;
        sb_q.push_back(model());
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("in_ready_after_start", {127'b0, bus.in_ready}, 128'd1);
        i = 0;
        guard = 0;
        while (i < N && guard < 200) begin
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = bus.in_valid ? ops[i] : rand128();
            if (pulse_start) bus.start = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = pulse_start;
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=%0d required=%0d", i, N);
        end
        check("out_valid_latency", {127'b0, bus.out_valid}, 128'd1);
        held = bus.out_sum;
        for (int d = 0; d < out_delay; d++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {127'b0, bus.out_valid}, 128'd1);
            check("stall_in_ready", {127'b0, bus.in_ready}, 128'd0);
            check("stall_sum_stable", bus.out_sum, held);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("idle_after_handshake", {126'b0, bus.busy, bus.out_valid}, 128'd0);
    endtask

    logic [127:0] max_pos;
    logic [127:0] min_neg;

    initial begin
        max_pos = {1'b0, {127{1'b1}}};
        min_neg = {1'b1, {127{1'b0}}};
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {127'b0, bus.in_ready}, 128'd0);
        check("reset_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("reset_out_sum", bus.out_sum, 128'd0);
        check("reset_flags_busy", {125'b0, bus.overflow, bus.underflow_q, bus.busy}, 128'd0);
        rst_n = 1'b1;

        // Basic sum.
        ops[0] = 128'h100; ops[1] = 128'h200; ops[2] = {{120{1'b1}}, 8'h00}; ops[3] = 128'h080;
        run_burst(1'b0, 0, 1'b0);

        // Positive overflow followed by zero operands.
        ops[0] = max_pos; ops[1] = 128'h100; ops[2] = 128'h0; ops[3] = 128'h0;
        run_burst(1'b0, 1, 1'b0);

        // Negative underflow.
        ops[0] = min_neg; ops[1] = min_neg; ops[2] = 128'h0; ops[3] = 128'h0;
        run_burst(1'b0, 0, 1'b0);

        // Accumulation continues from a saturated value.
        ops[0] = max_pos; ops[1] = max_pos; ops[2] = {128{1'b1}}; ops[3] = min_neg;
        run_burst(1'b0, 0, 1'b0);

        // Gaps plus output backpressure.
        ops[0] = 128'h300; ops[1] = 128'h40; ops[2] = 128'h5; ops[3] = 128'h1000;
        run_burst(1'b1, 5, 1'b0);

        // Start pulses while busy must not restart.
        ops[0] = 128'h11; ops[1] = 128'h22; ops[2] = 128'h33; ops[3] = 128'h44;
        run_burst(1'b1, 3, 1'b1);

        // Reset after two beats discards the partial burst.
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h777;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {127'b0, bus.busy}, 128'd0);
        check("async_reset_sum", bus.out_sum, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) ops[k] = 128'h100;
        run_burst(1'b0, 0, 1'b0);

        // Randomized bursts mixing boundary-heavy and arbitrary operands.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 4))
                    0: ops[k] = max_pos - 128'($urandom_range(0, 3));
                    1: ops[k] = min_neg + 128'($urandom_range(0, 3));
                    2: ops[k] = {{96{1'b0}}, $urandom()};
                    3: ops[k] = {{96{1'b1}}, $urandom()};
                    default: ops[k] = rand128();
                endcase
            end
            run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
